// File: rtl/fp_exception_add_pipe.sv
// Two-stage IEEE-754 add/sub special-case resolver: classifies the operands, then
// produces the final NaN/Inf/Zero result ahead of the main adder and counts delivered exceptions.
module fp_exception_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] q,
    output logic                 exc,
    output logic                 invalid,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     exc_cnt
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } fp_cls_t;

    function automatic fp_cls_t classify(input logic [W-1:0] x);
        logic    exp_ones;
        logic    exp_zero;
        logic    man_zero;
        fp_cls_t c;
        exp_ones = &x[W-2:MAN_W];
        exp_zero = ~|x[W-2:MAN_W];
        man_zero = ~|x[MAN_W-1:0];
        c.nan    = exp_ones & ~man_zero;
        c.snan   = exp_ones & ~man_zero & ~x[MAN_W-1];
        c.inf    = exp_ones & man_zero;
        c.zero   = exp_zero & man_zero;
        return c;
    endfunction

    logic             en;

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sbe_q, sbe_d;
    fp_cls_t          a_cls_q, a_cls_d;
    fp_cls_t          b_cls_q, b_cls_d;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     q_q, q_d;
    logic             exc_q, exc_d;
    logic             invalid_q, invalid_d;
    logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

    logic [W-1:0]     res;
    logic             res_exc;
    logic             res_inv;

    // A single advance enable keeps both stages in lockstep, so a stall never splits a pair.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        en         = !out_valid_q || out_ready;
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        sbe_d      = sbe_q;
        a_cls_d    = a_cls_q;
        b_cls_d    = b_cls_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d     = a;
                b_d     = b;
                sbe_d   = b[W-1] ^ sub;
                a_cls_d = classify(a);
                b_cls_d = classify(b);
            end
        end
    end

    always_comb begin
        res     = '0;
        res_exc = 1'b1;
        res_inv = a_cls_q.snan | b_cls_q.snan;
        if (a_cls_q.nan) begin
            res = {a_q[W-1], EXP_ONES, 1'b1, a_q[MAN_W-2:0]};
        end else if (b_cls_q.nan) begin
            res = {b_q[W-1], EXP_ONES, 1'b1, b_q[MAN_W-2:0]};
        end else if (a_cls_q.inf && b_cls_q.inf && (a_q[W-1] != sbe_q)) begin
            res     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            res_inv = 1'b1;
        end else if (a_cls_q.inf) begin
            res = {a_q[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_cls_q.inf) begin
            res = {sbe_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_cls_q.zero && b_cls_q.zero) begin
            res = {a_q[W-1] & sbe_q, {(W-1){1'b0}}};
        end else if (a_cls_q.zero) begin
            res = {sbe_q, b_q[W-2:0]};
        end else if (b_cls_q.zero) begin
            res = a_q;
        end else begin
            res_exc = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        q_d         = q_q;
        exc_d       = exc_q;
        invalid_d   = invalid_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                q_d       = res;
                exc_d     = res_exc;
                invalid_d = res_inv;
            end
        end
        // Clear wins over a coincident delivery.
        exc_cnt_d = exc_cnt_q;
        if (cnt_clr) begin
            exc_cnt_d = '0;
        end else if (out_valid_q && out_ready && exc_q && (exc_cnt_q != CNT_MAX)) begin
            exc_cnt_d = exc_cnt_q + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            exc_q       <= 1'b0;
            invalid_q   <= 1'b0;
            exc_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            exc_q       <= exc_d;
            invalid_q   <= invalid_d;
            exc_cnt_q   <= exc_cnt_d;
        end
    end

    // NOTE: stage-1 data is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        sbe_q   <= sbe_d;
        a_cls_q <= a_cls_d;
        b_cls_q <= b_cls_d;
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign exc       = exc_q;
    assign invalid   = invalid_q;
    assign exc_cnt   = exc_cnt_q;

endmodule

// File: tb/tb_fp_exception_add_pipe.sv
// Bench for fp_exception_add_pipe: directed special-case vectors, stall/ordering,
// randomized traffic against a behavioural model, reset behaviour and a wide/CNT_W=2 instance.
module tb_fp_exception_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, exc, invalid, cnt_clr;
    logic [15:0] a, b, q, exc_cnt;

    logic        in_valid32, in_ready32, sub32, out_valid32, out_ready32, exc32, invalid32, cnt_clr32;
    logic [31:0] a32, b32, q32;
    logic [1:0]  exc_cnt32;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        exc;
        logic        inv;
        logic [63:0] q;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] q;
        logic        e;
        logic        i;
    } vec_t;

    res_t sb[$];

    vec_t vecs [13] = '{
        '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b1, 1'b1},
        '{16'h7D00, 16'h3C00, 1'b0, 16'h7F00, 1'b1, 1'b1},
        '{16'h3C00, 16'hFE01, 1'b0, 16'hFE01, 1'b1, 1'b0},
        '{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b1, 1'b0},
        '{16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0},
        '{16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h3C00, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0},
        '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 1'b0, 1'b0},
        '{16'h3C00, 16'h0000, 1'b1, 16'h3C00, 1'b1, 1'b0},
        '{16'h7C00, 16'hFC00, 1'b1, 16'h7C00, 1'b1, 1'b0},
        '{16'hFC00, 16'h7D00, 1'b0, 16'h7F00, 1'b1, 1'b1},
        '{16'h8001, 16'h7C00, 1'b1, 16'hFC00, 1'b1, 1'b0},
        '{16'h0000, 16'h0005, 1'b1, 16'h8005, 1'b1, 1'b0}
    };

    fp_exception_add_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .exc(exc), .invalid(invalid), .cnt_clr(cnt_clr), .exc_cnt(exc_cnt)
    );

    fp_exception_add_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .q(q32), .exc(exc32), .invalid(invalid32), .cnt_clr(cnt_clr32), .exc_cnt(exc_cnt32)
    );

    // Behavioural model: decode fields arithmetically, then apply the result priority list.
    function automatic res_t ref_fp(input longint unsigned x, input longint unsigned y,
                                    input bit s, input int ew, input int mw);
        longint unsigned emax, mmask, qbit, sgn, xe, xm, ye, ym;
        bit   xs, ys, sbe, xnan, ynan, xinf, yinf, xz, yz;
        res_t r;
        int   w;
        w     = 1 + ew + mw;
        emax  = (64'd1 << ew) - 1;
        mmask = (64'd1 << mw) - 1;
        qbit  = 64'd1 << (mw - 1);
        sgn   = 64'd1 << (w - 1);
        xe = (x >> mw) & emax;  xm = x & mmask;  xs = ((x >> (w - 1)) & 1) != 0;
        ye = (y >> mw) & emax;  ym = y & mmask;  ys = ((y >> (w - 1)) & 1) != 0;
        sbe  = ys ^ s;
        xnan = (xe == emax) && (xm != 0);  xinf = (xe == emax) && (xm == 0);
        ynan = (ye == emax) && (ym != 0);  yinf = (ye == emax) && (ym == 0);
        xz   = (xe == 0) && (xm == 0);     yz   = (ye == 0) && (ym == 0);
        r.exc = 1'b1;
        r.inv = (xnan && ((xm & qbit) == 0)) || (ynan && ((ym & qbit) == 0));
        r.q   = 64'd0;
        if (xnan)                          r.q = (xs ? sgn : 64'd0) | (emax << mw) | xm | qbit;
        else if (ynan)                     r.q = (ys ? sgn : 64'd0) | (emax << mw) | ym | qbit;
        else if (xinf && yinf && xs != sbe) begin r.q = (emax << mw) | qbit; r.inv = 1'b1; end
        else if (xinf)                     r.q = (xs ? sgn : 64'd0) | (emax << mw);
        else if (yinf)                     r.q = (sbe ? sgn : 64'd0) | (emax << mw);
        else if (xz && yz)                 r.q = (xs && sbe) ? sgn : 64'd0;
        else if (xz)                       r.q = (sbe ? sgn : 64'd0) | (y & (sgn - 1));
        else if (yz)                       r.q = x;
        else                               r.exc = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] rand_op16();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 7))
            0:       return {s, 15'h0000};
            1:       return {s, 5'h1F, 10'h000};
            2:       return {s, 5'h1F, 1'b1, 9'($urandom)};
            3:       return {s, 5'h1F, 1'b0, 9'($urandom_range(1, 511))};
            4:       return {s, 5'h00, 10'($urandom_range(1, 1023))};
            default: return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
        endcase
    endfunction

    task automatic send_h(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                          output logic [15:0] oq, output logic oe, output logic oi,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        oq = q; oe = exc; oi = invalid;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 16'h7C00; b = 16'h7C00; sub = 1'b1;
        in_valid32 = 1'b1; out_ready32 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, exc, invalid} !== 3'b000 || q !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ov/exc/inv=%b%b%b q=%h, expected 000 q=0000",
                     out_valid, exc, invalid, q);
        end
        checks++;
        if (exc_cnt !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt_ready: got cnt=%h in_ready=%b, expected cnt=0000 in_ready=1",
                     exc_cnt, in_ready);
        end
        checks++;
        if ({out_valid32, exc32, invalid32, in_ready32} !== 4'b0001 || q32 !== 32'h0 || exc_cnt32 !== 2'd0) begin
            errors++;
            $display("FAIL reset_wide: got ov/exc/inv/rdy=%b%b%b%b q=%h cnt=%0d, expected 0001 q=0 cnt=0",
                     out_valid32, exc32, invalid32, in_ready32, q32, exc_cnt32);
        end
        in_valid = 1'b0; in_valid32 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] oq;
        logic        oe, oi;
        int          lat;
        for (int i = 0; i < 13; i++) begin
            send_h(vecs[i].a, vecs[i].b, vecs[i].s, oq, oe, oi, lat);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, expected 2", i, lat);
            end
            checks++;
            if ({oq, oe, oi} !== {vecs[i].q, vecs[i].e, vecs[i].i}) begin
                errors++;
                $display("FAIL directed_result[%0d]: got q=%h exc=%b inv=%b, expected q=%h exc=%b inv=%b",
                         i, oq, oe, oi, vecs[i].q, vecs[i].e, vecs[i].i);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        int got = 0;
        bit fire;
        @(negedge clk);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 5) out_ready = 1'b1;
            in_valid = (acc < 4);
            if (acc < 4) begin
                a = vecs[acc].a; b = vecs[acc].b; sub = vecs[acc].s;
            end
            #1;
            if (cyc == 4) begin
                checks++;
                if (in_ready !== 1'b0 || acc != 2) begin
                    errors++;
                    $display("FAIL b2b_stall_accepts: got in_ready=%b accepts=%0d, expected 0 and 2",
                             in_ready, acc);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || q !== vecs[0].q || exc !== vecs[0].e || invalid !== vecs[0].i) begin
                    errors++;
                    $display("FAIL b2b_hold[%0d]: got ov=%b q=%h exc=%b inv=%b, expected ov=1 q=%h exc=%b inv=%b",
                             cyc, out_valid, q, exc, invalid, vecs[0].q, vecs[0].e, vecs[0].i);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({q, exc, invalid} !== {vecs[got].q, vecs[got].e, vecs[got].i}) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got q=%h exc=%b inv=%b, expected q=%h exc=%b inv=%b",
                             got, q, exc, invalid, vecs[got].q, vecs[got].e, vecs[got].i);
                end
                got++;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4 || acc != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d delivered %0d accepted, expected 4 and 4", got, acc);
        end
    endtask

    task automatic test_random(input int n);
        res_t        e;
        int          mdl = 0;
        bit          hold = 1'b0;
        bit          popped, din, dout;
        logic [15:0] hq;
        logic        he, hi;
        e = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (exc_cnt !== 16'(mdl)) begin
                    errors++;
                    $display("FAIL rand_exc_cnt[%0d]: got %0d, expected %0d", i, exc_cnt, mdl);
                end
            end
            in_valid  = (i < n - 20) && ($urandom % 4 != 0);
            a         = rand_op16();
            b         = rand_op16();
            sub       = 1'($urandom);
            out_ready = (i >= n - 20) || ($urandom % 3 != 0);
            cnt_clr   = (i == 0) || ($urandom % 64 == 0);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b, expected %b", i, in_ready, !out_valid || out_ready);
            end
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || q !== hq || exc !== he || invalid !== hi) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: got ov=%b q=%h exc=%b inv=%b, expected ov=1 q=%h exc=%b inv=%b",
                             i, out_valid, q, exc, invalid, hq, he, hi);
                end
            end
            hold = out_valid && !out_ready;
            hq = q; he = exc; hi = invalid;
            dout   = out_valid && out_ready;
            din    = in_valid && in_ready;
            popped = 1'b0;
            if (dout) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious[%0d]: got q=%h with no outstanding input, expected no out_valid",
                             i, q);
                end else begin
                    e = sb.pop_front();
                    popped = 1'b1;
                    if ({q, exc, invalid} !== {e.q[15:0], e.exc, e.inv}) begin
                        errors++;
                        $display("FAIL rand_result[%0d]: got q=%h exc=%b inv=%b, expected q=%h exc=%b inv=%b",
                                 i, q, exc, invalid, e.q[15:0], e.exc, e.inv);
                    end
                end
            end
            if (din) sb.push_back(ref_fp(a, b, sub, 5, 10));
            if (cnt_clr) mdl = 0;
            else if (popped && e.exc && mdl < 65535) mdl++;
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0 || exc_cnt !== 16'(mdl)) begin
            errors++;
            $display("FAIL rand_drain: got %0d pending ov=%b cnt=%0d, expected 0 pending ov=0 cnt=%0d",
                     sb.size(), out_valid, exc_cnt, mdl);
        end
    endtask

    task automatic test_mid_reset;
        logic [15:0] oq;
        logic        oe, oi;
        int          lat;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h7C00; b = 16'h7C00; sub = 1'b1;
        @(negedge clk);
        a = 16'h3C00; b = 16'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || exc !== 1'b0 || q !== 16'h0) begin
            errors++;
            $display("FAIL midreset_async: got ov=%b exc=%b q=%h, expected 0 0 0000", out_valid, exc, q);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_ghost[%0d]: got out_valid=%b, expected 0", i, out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_h(16'h0000, 16'h3C00, 1'b1, oq, oe, oi, lat);
        checks++;
        if (lat != 2 || oq !== 16'hBC00 || oe !== 1'b1) begin
            errors++;
            $display("FAIL first_after_reset: got lat=%0d q=%h exc=%b, expected lat=2 q=bc00 exc=1",
                     lat, oq, oe);
        end
    endtask

    task automatic test_wide;
        int got = 0;
        int k;
        @(negedge clk);
        out_ready32 = 1'b1; cnt_clr32 = 1'b0; sub32 = 1'b0;
        a32 = 32'hFF80_0000; b32 = 32'h7F80_0000; in_valid32 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 4) in_valid32 = 1'b0;
            checks++;
            if (exc_cnt32 !== 2'(got < 3 ? got : 3)) begin
                errors++;
                $display("FAIL wide_cnt[%0d]: got %0d, expected %0d", c, exc_cnt32, got < 3 ? got : 3);
            end
            if (out_valid32) begin
                checks++;
                if ({q32, exc32, invalid32} !== {32'h7FC0_0000, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL wide_result[%0d]: got q=%h exc=%b inv=%b, expected q=7fc00000 exc=1 inv=1",
                             got, q32, exc32, invalid32);
                end
                got++;
            end
        end
        checks++;
        if (got != 5 || exc_cnt32 !== 2'd3) begin
            errors++;
            $display("FAIL wide_saturate: got %0d delivered cnt=%0d, expected 5 and 3", got, exc_cnt32);
        end
        cnt_clr32 = 1'b1;
        @(negedge clk);
        cnt_clr32 = 1'b0;
        checks++;
        if (exc_cnt32 !== 2'd0) begin
            errors++;
            $display("FAIL wide_clear: got %0d, expected 0", exc_cnt32);
        end
        for (int pass = 0; pass < 2; pass++) begin
            in_valid32 = 1'b1;
            @(negedge clk);
            in_valid32 = 1'b0;
            k = 0;
            while (!out_valid32 && k < 8) begin
                @(negedge clk);
                k++;
            end
            checks++;
            if (out_valid32 !== 1'b1) begin
                errors++;
                $display("FAIL wide_timeout[%0d]: got no out_valid, expected a result", pass);
            end
            cnt_clr32 = (pass == 1);
            @(negedge clk);
            cnt_clr32 = 1'b0;
            checks++;
            if (exc_cnt32 !== (pass == 1 ? 2'd0 : 2'd1) || out_valid32 !== 1'b0) begin
                errors++;
                $display("FAIL wide_clr_priority[%0d]: got cnt=%0d ov=%b, expected cnt=%0d ov=0",
                         pass, exc_cnt32, out_valid32, pass == 1 ? 0 : 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected the bench to finish");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; a = '0; b = '0; sub = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; cnt_clr32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(2000);
        test_mid_reset();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
